// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MIPS32 EX/MEM stage.
// Latches a load/store request, holds the pipeline for LATENCY BUSY cycles,
// performs the access on the last BUSY edge and reports the result in DONE.
module dmem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        rd_valid,
  output logic        addr_error,
  output logic        stall
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t               state;
  logic [3:0]           cnt;
  req_t                 lat;
  logic [31:0]          mem [DEPTH];
  logic                 req;
  logic                 lat_err;
  logic                 fire;
  logic [ADDR_BITS-1:0] idx;

  assign req     = mem_read | mem_write;
  assign idx     = lat.addr[ADDR_BITS+1:2];
  // misaligned, beyond the storage window, or an ambiguous read+write
  assign lat_err = (lat.addr[1:0] != 2'b00)
                 | ((lat.addr >> (ADDR_BITS + 2)) != 32'd0)
                 | (lat.rd & lat.wr);
  // last BUSY edge: the access itself happens here
  assign fire    = (state == BUSY) && (cnt == 4'd0);

  // stall is combinational so the request cycle itself is already held
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    stall = req;
        BUSY:    stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  // control FSM with registered result and strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat        <= '0;
      read_data  <= 32'd0;
      rd_valid   <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      rd_valid   <= 1'b0;
      addr_error <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            lat   <= '{rd: mem_read, wr: mem_write, addr: addr, wdata: write_data};
            cnt   <= 4'(LATENCY - 1);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state      <= DONE;
            addr_error <= lat_err;
            rd_valid   <= lat.rd & ~lat_err;
            if (lat_err)     read_data <= 32'd0;
            else if (lat.rd) read_data <= mem[idx];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // storage: cleared on reset, written only by a good store on the last BUSY edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (fire && lat.wr && !lat_err) begin
      mem[idx] <= lat.wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with LATENCY=2, ADDR_BITS=8.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] addr, write_data;
  logic [31:0] read_data;
  logic        rd_valid, addr_error, stall;

  int  tests = 0;
  int  fails = 0;
  time done_t;
  time prev_t;

  dmem_responder #(.ADDR_BITS(8), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .write_data(write_data), .read_data(read_data),
    .rd_valid(rd_valid), .addr_error(addr_error), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one full access starting in an IDLE cycle; returns in the IDLE cycle after DONE
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_err, input logic exp_rv,
                        input logic [31:0] exp_rdata);
    chk({tag, ":idle_rv"},  {31'd0, rd_valid},   32'd0);
    chk({tag, ":idle_err"}, {31'd0, addr_error}, 32'd0);
    mem_read = rd; mem_write = wr; addr = a; write_data = wd;
    #1;
    chk({tag, ":stall_c0"}, {31'd0, stall}, 32'd1);
    for (int c = 1; c <= LAT; c++) begin
      tick();
      chk($sformatf("%s:stall_c%0d", tag, c), {31'd0, stall}, 32'd1);
      chk($sformatf("%s:busy_rv_c%0d", tag, c), {31'd0, rd_valid}, 32'd0);
    end
    tick();
    done_t = $time;
    chk({tag, ":done_stall"}, {31'd0, stall},      32'd0);
    chk({tag, ":done_rv"},    {31'd0, rd_valid},   {31'd0, exp_rv});
    chk({tag, ":done_err"},   {31'd0, addr_error}, {31'd0, exp_err});
    chk({tag, ":done_rdata"}, read_data,           exp_rdata);
    mem_read = 1'b0; mem_write = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; write_data = '0;
    done_t = 0; prev_t = 0;

    // 1. reset and idle; stall is held low during reset even with a request
    tick();
    mem_read = 1'b1;
    #1;
    chk("rst:stall_forced", {31'd0, stall}, 32'd0);
    mem_read = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("rst:rdata", read_data,           32'd0);
    chk("rst:rv",    {31'd0, rd_valid},   32'd0);
    chk("rst:err",   {31'd0, addr_error}, 32'd0);
    chk("rst:stall", {31'd0, stall},      32'd0);
    tick();
    chk("idle:stall", {31'd0, stall}, 32'd0);

    // 2. store then load
    access("st10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    access("ld10", 1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF);

    // 3. misaligned and out-of-range
    access("ld12",  1'b1, 1'b0, 32'h12,  32'h0,         1'b1, 1'b0, 32'h0);
    access("st400", 1'b0, 1'b1, 32'h400, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0);
    access("ld00",  1'b1, 1'b0, 32'h0,   32'h0,         1'b0, 1'b1, 32'h0);

    // 4. simultaneous read and write leaves the word untouched
    access("st20", 1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    access("rw20", 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    access("ld20", 1'b1, 1'b0, 32'h20, 32'h0,         1'b0, 1'b1, 32'h1234_5678);

    // 5. back-to-back loads, strobes LAT+2 cycles apart
    access("st0", 1'b0, 1'b1, 32'h0, 32'd1, 1'b0, 1'b0, 32'h1234_5678);
    access("st4", 1'b0, 1'b1, 32'h4, 32'd2, 1'b0, 1'b0, 32'h1234_5678);
    access("st8", 1'b0, 1'b1, 32'h8, 32'd3, 1'b0, 1'b0, 32'h1234_5678);
    access("bb0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd1);
    prev_t = done_t;
    access("bb4", 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, 32'd2);
    chk("bb:gap1", 32'(done_t - prev_t), 32'd40);
    prev_t = done_t;
    access("bb8", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 32'd3);
    chk("bb:gap2", 32'(done_t - prev_t), 32'd40);

    // 6. reset in cycle 1 of a store aborts it
    mem_write = 1'b1; addr = 32'h30; write_data = 32'h5555_5555;
    #1;
    chk("rstmid:stall_c0", {31'd0, stall}, 32'd1);
    tick();
    reset = 1'b1;
    #1;
    chk("rstmid:stall_rst", {31'd0, stall}, 32'd0);
    mem_write = 1'b0;
    tick();
    tick();
    chk("rstmid:rdata_rst", read_data, 32'd0);
    reset = 1'b0;
    tick();
    access("ld30", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 32'h0);
    access("ld04", 1'b1, 1'b0, 32'h4,  32'h0, 1'b0, 1'b1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
